// File: rtl/unloader_pkg.sv
// rtl/unloader_pkg.sv - shared state type and constants for the result unloader
package unloader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 3;
  localparam int OUT_W          = 8;
  localparam int SREG_W         = BYTES_PER_WORD * OUT_W;

endpackage

// File: rtl/result_unloader_if.sv
// rtl/result_unloader_if.sv - result RAM read port plus byte-serial output stream
interface result_unloader_if #(
  parameter int ADDR_W  = 4,
  parameter int P_WIDTH = 18
);
  import unloader_pkg::*;

  logic               ram_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [P_WIDTH-1:0] ram_rdata;
  logic [OUT_W-1:0]   P_out;
  logic               p_valid;
  logic               p_ready;

  // Unloader side: drives the RAM read port and the byte stream
  modport master (
    output ram_en,
    output ram_addr,
    input  ram_rdata,
    output P_out,
    output p_valid,
    input  p_ready
  );

  // Environment side: RAM answers reads, sink consumes bytes
  modport slave (
    input  ram_en,
    input  ram_addr,
    output ram_rdata,
    input  P_out,
    input  p_valid,
    output p_ready
  );

endinterface

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - streams the finished result matrix out as MSB-first bytes
module result_unloader
  import unloader_pkg::*;
#(
  parameter int N_RESULTS = 16,
  parameter int ADDR_W    = 4,
  parameter int P_WIDTH   = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 unload_start,
  result_unloader_if.master    bus,
  output logic                 busy,
  output logic                 unload_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_RESULTS - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [1:0]         byte_cnt;
  logic [SREG_W-1:0]  sreg;
  logic               xfer;

  assign xfer = (state == SEND) && bus.p_ready;

  // Unload sequencer: fetch one word, send its three bytes, advance or finish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      byte_cnt <= '0;
      sreg     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (unload_start) begin
            idx      <= '0;
            byte_cnt <= '0;
            state    <= READ;
          end
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          // RAM data for idx is valid now; zero-extend into the shift register
          sreg     <= SREG_W'(bus.ram_rdata);
          byte_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (xfer) begin
            sreg <= sreg << OUT_W;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              if (idx == LAST_IDX) begin
                state <= DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= READ;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_en   = (state == READ);
  assign bus.ram_addr = idx;
  assign bus.p_valid  = (state == SEND);
  assign bus.P_out    = sreg[SREG_W-1 -: OUT_W];
  assign busy         = (state != IDLE);
  assign unload_done  = (state == DONE);

endmodule

// File: doc/result_unloader.md
# result_unloader

Reads the finished result matrix P out of the result RAM after the controller raises `finish`, and streams it off-chip byte-serially over an 8-bit valid/ready port. It is the output-side counterpart of the X_load/valid_input loading path. It sits beside `logic_top` under the top level and owns the RAM read port while it is busy. Results are sent in ascending address order, each zero-extended to 24 bits and sent MSB byte first.

## Interface

**Parameters**
- `N_RESULTS`, default 16: number of result words (4x4 P matrix).
- `ADDR_W`, default 4: RAM address width; must satisfy 2^ADDR_W >= N_RESULTS.
- `P_WIDTH`, default 18: result word width; legal range 17..24.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `unload_start`, in, 1: one-cycle pulse, driven from the controller's `finish`.
- `ram_en`, out, 1: RAM read enable.
- `ram_addr`, out, ADDR_W: RAM read address.
- `ram_rdata`, in, P_WIDTH: RAM read data; valid one cycle after `ram_en`.
- `P_out`, out, 8: output byte.
- `p_valid`, out, 1: `P_out` holds a valid byte.
- `p_ready`, in, 1: sink accepts the byte; a transfer happens when `p_valid && p_ready` at a rising edge.
- `busy`, out, 1: high in every state except IDLE.
- `unload_done`, out, 1: one-cycle pulse after the last byte transfers.

## Operation

- **States**
  - IDLE: waits for `unload_start`.
  - READ: issues `ram_en`=1 and `ram_addr`=idx.
  - WAIT: covers the RAM read latency; `ram_rdata` is captured into a 24-bit shift register at the end of this state.
  - SEND: presents the shift-register bytes.
  - DONE: asserts `unload_done`.
- **Transitions**
  - IDLE -> READ on `unload_start`; idx cleared to 0.
  - READ -> WAIT unconditionally.
  - WAIT -> SEND unconditionally.
  - In SEND, each transfer shifts the register left by 8 and increments the 2-bit byte counter (0..2).
  - On the third transfer: if idx == N_RESULTS-1, go to DONE; otherwise idx+1 and go to READ.
  - DONE -> IDLE unconditionally.
- **Byte order and width**
  - Capture value is {zeros, `ram_rdata`}, i.e. zero-extended to 24 bits.
  - `P_out` = sreg[23:16], so byte 0 = bits 23:16, byte 1 = bits 15:8, byte 2 = bits 7:0.
- **Outputs by state**
  - `p_valid` = (state == SEND), combinational from the state register.
  - `ram_en` = (state == READ).
  - `ram_addr` = idx at all times.
- **Handshake**
  - While `p_valid`=1 and `p_ready`=0, `P_out` holds stable and no state changes.
  - `p_valid` never drops without a transfer.
  - `p_ready` is ignored outside SEND.
- **Boundary conditions**
  - `unload_start` while busy: ignored; no restart and no idx reset.
  - `unload_start` in the same cycle as DONE: ignored.
  - Reset asserted mid-stream (any state): returns to IDLE immediately; the partial stream is abandoned and no `unload_done` pulse is generated.
  - `p_ready` held high permanently: three transfers per result on consecutive cycles.

## Timing

- Reset values: state=IDLE, idx=0, byte counter=0, sreg=0, `P_out`=0, `p_valid`=0, `ram_en`=0, `ram_addr`=0, `busy`=0, `unload_done`=0.
- `unload_start` sampled at edge E0: READ in cycle 1, WAIT in cycle 2, first `p_valid` in cycle 3.
- Between results: 2 bubble cycles (READ, WAIT) after the third byte of a result transfers.
- Full unload with `p_ready`=1 throughout: N_RESULTS*5 + 1 cycles from E0 to the `unload_done` cycle; 81 cycles at defaults.
- `unload_done` is high for exactly the one cycle following the last transfer; `busy` is still 1 in that cycle and 0 in the next.

## Structure

- Shared package `unloader_pkg`:
  - state enum: IDLE, READ, WAIT, SEND, DONE.
  - constant BYTES_PER_WORD = 3.
  - constant OUT_W = 8.
- Single flat module; no sub-module needed. The shift register and counters are small enough to stay inline.

## Test plan

- **Basic stream:** RAM preloaded with addr i -> 0x10000 + i; pulse `unload_start`; `p_ready`=1. Require 48 bytes in order 01 00 00, 01 00 01, ..., 01 00 0F, and `unload_done` exactly 81 cycles after the start edge.
- **Backpressure:** drop `p_ready` for 4 cycles while byte 1 of word 5 (0x00) is presented. Require `P_out` and `p_valid` stable throughout, no byte lost or duplicated, and total time extended by 4 cycles.
- **Width edge:** word 0 = 0x3FFFF (max at P_WIDTH=18). Require bytes 03 FF FF; upper 6 bits of byte 0 are zero.
- **Start while busy:** second `unload_start` at cycle 20. Require it to be ignored: same 48-byte sequence and a single `unload_done`.
- **Reset mid-stream:** assert `rst`=0 during word 7. Require all outputs at reset values on the next sample and no `unload_done`; a fresh start afterwards replays from address 0.
- **Idle sink:** `p_ready`=1 with no start. Require `p_valid`, `ram_en` and `busy` to stay 0 for 50 cycles.
